// File: rtl/gb_ppu_pkg.sv
// Shared PPU definitions for the background tile-map fetcher.
//   MAP0_BASE / MAP1_BASE : VRAM offsets of the two 32x32 background tile maps
//   TILES_PER_LINE        : tile indices fetched per visible line
//   MAP_W / COL_W         : tile-map width in tiles and the matching index width
//   ST_*                  : fetcher FSM state encoding
package gb_ppu_pkg;

  localparam logic [12:0] MAP0_BASE      = 13'h1800;
  localparam logic [12:0] MAP1_BASE      = 13'h1C00;
  localparam int          TILES_PER_LINE = 20;
  localparam int          MAP_W          = 32;
  localparam int          COL_W          = $clog2(MAP_W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/bg_tilemap_fetcher_if.sv
// Bus bundle between the tile-map fetcher, the VRAM read arbiter and scanline RAM port A.
//   vram_rd_req/vram_addr   : read request, address held stable while req is high
//   vram_rd_ack/vram_rd_data: arbiter accepts; data valid in the ack cycle
//   sl_wr_en/sl_addr/sl_wr_data : scanline RAM port A write
// master = fetcher side, slave = arbiter / RAM side.
interface bg_tilemap_fetcher_if #(
  parameter int VRAM_AW = 13,
  parameter int SL_AW   = 5
);
  logic               vram_rd_req;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_rd_ack;
  logic [7:0]         vram_rd_data;
  logic               sl_wr_en;
  logic [SL_AW-1:0]   sl_addr;
  logic [7:0]         sl_wr_data;

  modport master (
    output vram_rd_req, vram_addr,
    input  vram_rd_ack, vram_rd_data,
    output sl_wr_en, sl_addr, sl_wr_data
  );

  modport slave (
    input  vram_rd_req, vram_addr,
    output vram_rd_ack, vram_rd_data,
    input  sl_wr_en, sl_addr, sl_wr_data
  );
endinterface

// File: rtl/bg_map_addr.sv
// Combinational tile-map address generator.
//   i_map_sel : selects map at 0x1800 (0) or 0x1C00 (1)
//   i_row     : tile row within the map
//   i_col0    : first tile column of the line
//   i_idx     : tile number within the line
//   o_addr    : VRAM byte address of the tile index
module bg_map_addr
  import gb_ppu_pkg::*;
#(
  parameter int VRAM_AW = 13
) (
  input  logic               i_map_sel,
  input  logic [COL_W-1:0]   i_row,
  input  logic [COL_W-1:0]   i_col0,
  input  logic [COL_W-1:0]   i_idx,
  output logic [VRAM_AW-1:0] o_addr
);

  logic [COL_W-1:0] w_col;

  // Truncating add wraps the fetch around the 32-tile-wide map.
  assign w_col  = i_col0 + i_idx;
  assign o_addr = VRAM_AW'(i_map_sel ? MAP1_BASE : MAP0_BASE) | VRAM_AW'({i_row, w_col});

endmodule

// File: rtl/bg_tilemap_fetcher.sv
// Background tile-map fetcher: at the start of a line reads NUM_TILES tile indices
// from VRAM and writes them into scanline RAM port A at addresses 0..NUM_TILES-1.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, abort          : line-start pulse (ignored while busy), abort to IDLE
//   ly, scy, scx, map_sel : line number, scroll registers, map select (latched per line)
//   bus                   : VRAM read handshake + scanline RAM write port (master)
//   fine_x, fine_y        : latched pixel offsets for the downstream shifter
//   busy, done            : fetch in progress, one-cycle completion pulse
module bg_tilemap_fetcher
  import gb_ppu_pkg::*;
#(
  parameter int NUM_TILES = TILES_PER_LINE,
  parameter int VRAM_AW   = 13,
  parameter int SL_AW     = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           ly,
  input  logic [7:0]           scy,
  input  logic [7:0]           scx,
  input  logic                 map_sel,
  bg_tilemap_fetcher_if.master bus,
  output logic [2:0]           fine_x,
  output logic [2:0]           fine_y,
  output logic                 busy,
  output logic                 done
);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [SL_AW-1:0]   r_idx;
  logic [COL_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col0;
  logic               r_map_sel;
  logic [2:0]         r_fine_x;
  logic [2:0]         r_fine_y;
  logic [7:0]         r_data;
  logic [7:0]         w_line;
  logic               w_last;
  logic [VRAM_AW-1:0] w_addr;

  // Vertical position wraps modulo 256 by plain 8-bit truncation.
  assign w_line = ly + scy;
  assign w_last = (r_idx == SL_AW'(NUM_TILES - 1));

  bg_map_addr #(.VRAM_AW(VRAM_AW)) u_map_addr (
    .i_map_sel (r_map_sel),
    .i_row     (r_row),
    .i_col0    (r_col0),
    .i_idx     (COL_W'(r_idx)),
    .o_addr    (w_addr)
  );

  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_nxt = ST_LATCH;
        ST_LATCH: w_state_nxt = ST_REQ;
        ST_REQ:   if (bus.vram_rd_ack) w_state_nxt = ST_WRITE;
        ST_WRITE: w_state_nxt = w_last ? ST_DONE : ST_REQ;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_row     <= '0;
      r_col0    <= '0;
      r_map_sel <= 1'b0;
      r_fine_x  <= 3'd0;
      r_fine_y  <= 3'd0;
      r_data    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (!abort) begin
        case (r_state)
          ST_LATCH: begin
            // Per-line snapshot: later register writes only affect the next line.
            r_row     <= w_line[7:3];
            r_col0    <= scx[7:3];
            r_map_sel <= map_sel;
            r_fine_x  <= scx[2:0];
            r_fine_y  <= w_line[2:0];
            r_idx     <= '0;
          end
          ST_REQ:   if (bus.vram_rd_ack) r_data <= bus.vram_rd_data;
          ST_WRITE: if (!w_last) r_idx <= r_idx + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Outputs decode the registered state, so req drops the cycle after ack.
  assign bus.vram_rd_req = (r_state == ST_REQ);
  assign bus.vram_addr   = bus.vram_rd_req ? w_addr : '0;
  assign bus.sl_wr_en    = (r_state == ST_WRITE);
  assign bus.sl_addr     = bus.sl_wr_en ? r_idx : '0;
  assign bus.sl_wr_data  = r_data;
  assign fine_x          = r_fine_x;
  assign fine_y          = r_fine_y;
  assign busy            = (r_state == ST_LATCH) || (r_state == ST_REQ) || (r_state == ST_WRITE);
  assign done            = (r_state == ST_DONE);

endmodule

// File: tb/tb_bg_tilemap_fetcher.sv
// Testbench for bg_tilemap_fetcher: table of per-line scroll settings with hand-computed
// addresses, plus sequences for ack stall, abort, restart-while-busy and async reset.
module tb_bg_tilemap_fetcher;

  typedef struct {
    logic [7:0]  ly;
    logic [7:0]  scy;
    logic [7:0]  scx;
    logic        map_sel;
    logic [2:0]  fx;
    logic [2:0]  fy;
    logic [12:0] a0;
    logic [12:0] a2;
    logic [12:0] a19;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [7:0] ly;
  logic [7:0] scy;
  logic [7:0] scx;
  logic       map_sel;
  logic [2:0] fine_x;
  logic [2:0] fine_y;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[5];
  logic [7:0] sl_mem [20];

  bg_tilemap_fetcher_if #(.VRAM_AW(13), .SL_AW(5)) bus ();

  bg_tilemap_fetcher #(.NUM_TILES(20), .VRAM_AW(13), .SL_AW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .ly      (ly),
    .scy     (scy),
    .scx     (scx),
    .map_sel (map_sel),
    .bus     (bus),
    .fine_x  (fine_x),
    .fine_y  (fine_y),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] model_addr(input vec_t v, input int k);
    logic [7:0] line;
    logic [4:0] col;
    line = v.ly + v.scy;
    col  = 5'((int'(v.scx[7:3]) + k) % 32);
    return (v.map_sel ? 13'h1C00 : 13'h1800) + {3'b000, line[7:3], col};
  endfunction

  // Arbiter returns an address-dependent byte so ordering errors show up in the data.
  function automatic logic [7:0] rd_data(input logic [12:0] a);
    return a[7:0] ^ 8'h3C ^ {3'b000, a[12:8]};
  endfunction

  // One line fetch. stall_tile/abort_tile = -1 disables; disturb changes scx and re-pulses start.
  task automatic run_line(input vec_t v, input int stall_tile, input int stall_n,
                          input int abort_tile, input bit disturb);
    int n_wr;
    int wait_n;
    int exp_done;
    bit finished;
    bit aborted;
    ly = v.ly; scy = v.scy; scx = v.scx; map_sel = v.map_sel;
    @(negedge clk);
    start = 1'b1;
    n_wr = 0; wait_n = 0; finished = 1'b0; aborted = 1'b0;
    exp_done = 42 + ((stall_tile >= 0) ? stall_n : 0);
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      bus.vram_rd_ack = 1'b0;
      if (disturb && cyc == 3) scx = ~v.scx;
      if (disturb && cyc == 9) start = 1'b1;
      if (cyc == 2) begin
        check("fine_x_latched", fine_x, v.fx);
        check("fine_y_latched", fine_y, v.fy);
      end
      if (aborted) begin
        check("abort_next_idle", {bus.vram_rd_req, bus.sl_wr_en, busy, done}, 4'b0000);
        for (int q = 0; q < 6; q++) begin
          @(negedge clk);
          check("abort_quiet", {bus.vram_rd_req, done}, 2'b00);
        end
        check("abort_writes", n_wr, abort_tile + 1);
        finished = 1'b1;
      end else begin
        if (bus.vram_rd_req) begin
          check("req_addr", bus.vram_addr, model_addr(v, n_wr));
          check("req_no_wr", bus.sl_wr_en, 0);
          if (n_wr == 0)  check("addr_tile0", bus.vram_addr, v.a0);
          if (n_wr == 2)  check("addr_tile2", bus.vram_addr, v.a2);
          if (n_wr == 19) check("addr_tile19", bus.vram_addr, v.a19);
          if (n_wr == stall_tile && wait_n < stall_n) begin
            wait_n++;
          end else begin
            bus.vram_rd_ack  = 1'b1;
            bus.vram_rd_data = rd_data(bus.vram_addr);
          end
        end
        if (bus.sl_wr_en) begin
          check("wr_addr", bus.sl_addr, n_wr);
          check("wr_data", bus.sl_wr_data, rd_data(model_addr(v, n_wr)));
          if (bus.sl_addr < 5'd20) sl_mem[bus.sl_addr] = bus.sl_wr_data;
          if (n_wr == abort_tile) begin
            abort   = 1'b1;
            aborted = 1'b1;
          end
          n_wr++;
        end
        if (done) begin
          check("done_latency", cyc, exp_done);
          check("done_writes", n_wr, 20);
          check("done_not_busy", busy, 0);
          check("fine_x_held", fine_x, v.fx);
          finished = 1'b1;
        end
      end
    end
    if (!finished) check("timeout", 0, 1);
    bus.vram_rd_ack = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    if (!aborted) begin
      for (int q = 0; q < 4; q++) begin
        @(negedge clk);
        check("idle_after_done", {busy, done, bus.vram_rd_req}, 3'b000);
      end
    end
  endtask

  initial begin
    //            ly     scy    scx    map   fx    fy    a0        a2        a19
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 13'h1800, 13'h1802, 13'h1813};
    vecs[1] = '{8'h10, 8'hF8, 8'hF0, 1'b1, 3'd0, 3'd0, 13'h1C3E, 13'h1C20, 13'h1C31};
    vecs[2] = '{8'h26, 8'h03, 8'h0D, 1'b0, 3'd5, 3'd1, 13'h18A1, 13'h18A3, 13'h18B4};
    vecs[3] = '{8'h8F, 8'h00, 8'h7F, 1'b1, 3'd7, 3'd7, 13'h1E2F, 13'h1E31, 13'h1E22};
    vecs[4] = '{8'h01, 8'hFF, 8'hFF, 1'b0, 3'd7, 3'd0, 13'h181F, 13'h1801, 13'h1812};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    ly = 8'h00; scy = 8'h00; scx = 8'h00; map_sel = 1'b0;
    bus.vram_rd_ack = 1'b0; bus.vram_rd_data = 8'h00;
    for (int k = 0; k < 20; k++) sl_mem[k] = 8'hEE;
    repeat (3) @(negedge clk);
    check("rst_req", bus.vram_rd_req, 0);
    check("rst_vaddr", bus.vram_addr, 0);
    check("rst_wr", {bus.sl_wr_en, bus.sl_addr, bus.sl_wr_data}, 0);
    check("rst_fine", {fine_x, fine_y}, 0);
    check("rst_busy_done", {busy, done}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: five scroll / map configurations, ack in every REQ cycle.
    for (int i = 0; i < 5; i++) run_line(vecs[i], -1, 0, -1, 1'b0);

    // Arbiter stalls tile 7 for five cycles.
    run_line(vecs[0], 7, 5, -1, 1'b0);

    // Abort during WRITE of tile 10: entries 0..10 written, the rest untouched.
    for (int k = 0; k < 20; k++) sl_mem[k] = 8'hEE;
    run_line(vecs[2], -1, 0, 10, 1'b0);
    for (int k = 0; k < 20; k++)
      check("abort_sl_mem", sl_mem[k], (k <= 10) ? 32'(rd_data(model_addr(vecs[2], k))) : 32'hEE);

    // Second start mid-fetch plus scx change after LATCH.
    run_line(vecs[1], -1, 0, -1, 1'b1);

    // Start and abort together: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      check("start_abort_quiet", {busy, bus.vram_rd_req}, 2'b00);
    end

    // Async reset while holding in REQ.
    ly = vecs[2].ly; scy = vecs[2].scy; scx = vecs[2].scx; map_sel = vecs[2].map_sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_req", bus.vram_rd_req, 1);
    check("pre_rst_fine_x", fine_x, 5);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_req", {bus.vram_rd_req, bus.vram_addr}, 0);
    check("async_rst_busy", {busy, done, bus.sl_wr_en}, 0);
    check("async_rst_fine", {fine_x, fine_y}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_line(vecs[3], -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
